// File: rtl/nco_pkg.sv
// nco_pkg: shared definitions for the NCO sweep sequencer.
//   NCO_SIZE / NCO_DWELL_W : default tuning-word and dwell-counter widths
//   MODE_*                 : sweep-mode encodings carried on cfg_mode
//   sweep_state_t          : sequencer FSM encoding (also exported for debug)
package nco_pkg;

  localparam int NCO_SIZE    = 26;
  localparam int NCO_DWELL_W = 16;

  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_LOOP     = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;
  // Encoding 2'd3 is treated as one-shot.

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DWELL = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } sweep_state_t;

endpackage

// File: rtl/nco_sweep_step.sv
// nco_sweep_step: combinational next-tuning-word calculator with clamp.
//   cur          : current tuning word
//   step         : unsigned step magnitude
//   target       : end point of the current leg
//   dir_up       : 1 = add step, 0 = subtract step
//   nxt          : next tuning word, clamped to target on reach/overshoot
//   reached_stop : next value meets or passes target (carry/borrow included)
module nco_sweep_step #(
  parameter int SIZE = 26
) (
  input  logic [SIZE-1:0] cur,
  input  logic [SIZE-1:0] step,
  input  logic [SIZE-1:0] target,
  input  logic            dir_up,
  output logic [SIZE-1:0] nxt,
  output logic            reached_stop
);

  // One extra bit so a carry or borrow out of SIZE bits is visible and the
  // result can never wrap.
  logic [SIZE:0] sum;
  logic [SIZE:0] diff;

  assign sum  = {1'b0, cur} + {1'b0, step};
  assign diff = {1'b0, cur} - {1'b0, step};

  always_comb begin
    reached_stop = 1'b0;
    nxt          = target;
    if (dir_up) begin
      reached_stop = (sum >= {1'b0, target});
      nxt          = reached_stop ? target : sum[SIZE-1:0];
    end else begin
      reached_stop = diff[SIZE] || (diff[SIZE-1:0] <= target);
      nxt          = reached_stop ? target : diff[SIZE-1:0];
    end
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: linear frequency-sweep sequencer driving phase_acc's M.
//   clk, reset     : clock, synchronous active-low reset
//   cfg_valid/ready: config handshake; a field set is taken on a clock edge
//                    where cfg_valid and cfg_ready are both high. cfg_ready is
//                    high only while idle; cfg_valid is simply held off while
//                    a sweep runs.
//   cfg_start/stop/step/dwell/mode : sweep configuration fields
//   go, abort      : start (idle only) / stop immediately (abort wins)
//   m_out          : tuning word; m_update pulses when it loads or changes
//   acc_rst        : 1-cycle reset pulse to phase_acc at sweep (re)start
//   busy, done     : sweep running / one-shot completion pulse
//   dbg_state      : current FSM state
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int SIZE    = NCO_SIZE,
  parameter int DWELL_W = NCO_DWELL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [SIZE-1:0]    cfg_start,
  input  logic [SIZE-1:0]    cfg_stop,
  input  logic [SIZE-1:0]    cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic               go,
  input  logic               abort,
  output logic [SIZE-1:0]    m_out,
  output logic               m_update,
  output logic               acc_rst,
  output logic               busy,
  output logic               done,
  output sweep_state_t       dbg_state
);

  sweep_state_t       state;
  logic [SIZE-1:0]    sh_start, sh_stop, sh_step;
  logic [DWELL_W-1:0] sh_dwell, dwell_cnt;
  logic [1:0]         sh_mode;
  // Current leg end points; ping-pong swaps them at each turn-around.
  logic [SIZE-1:0]    leg_start, leg_stop;
  logic               dir_up;

  logic               at_stop, fixed_tone;
  logic [SIZE-1:0]    step_target, step_next;
  logic               step_dir, step_reached;

  assign at_stop    = (m_out == leg_stop);
  assign fixed_tone = (sh_step == '0) || (sh_start == sh_stop);
  // At a ping-pong turn-around the next value heads back toward leg_start.
  assign step_target = at_stop ? leg_start : leg_stop;
  assign step_dir    = at_stop ? ~dir_up : dir_up;
  assign dbg_state   = state;

  nco_sweep_step #(.SIZE(SIZE)) u_step (
    .cur          (m_out),
    .step         (sh_step),
    .target       (step_target),
    .dir_up       (step_dir),
    .nxt          (step_next),
    .reached_stop (step_reached)
  );

  // DWELL and STEP share the hold logic: every M value (including start)
  // is visible for exactly dwell+1 cycles, the first of which is the
  // LOAD-exit / STEP cycle. Loop restarts reload start directly so the
  // stop value is not held an extra cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      m_out     <= '0;
      sh_start  <= '0;
      sh_stop   <= '0;
      sh_step   <= '0;
      sh_dwell  <= '0;
      sh_mode   <= '0;
      leg_start <= '0;
      leg_stop  <= '0;
      dir_up    <= 1'b1;
      dwell_cnt <= '0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      m_update  <= 1'b0;
      acc_rst   <= 1'b0;
    end else begin
      m_update <= 1'b0;
      acc_rst  <= 1'b0;
      done     <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state     <= ST_IDLE;
        busy      <= 1'b0;
        cfg_ready <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cfg_valid) begin
              sh_start <= cfg_start;
              sh_stop  <= cfg_stop;
              sh_step  <= cfg_step;
              sh_dwell <= cfg_dwell;
              sh_mode  <= cfg_mode;
            end
            if (go && !abort) begin
              state     <= ST_LOAD;
              busy      <= 1'b1;
              cfg_ready <= 1'b0;
            end
          end
          ST_LOAD: begin
            m_out     <= sh_start;
            leg_start <= sh_start;
            leg_stop  <= sh_stop;
            dir_up    <= (sh_start <= sh_stop);
            dwell_cnt <= sh_dwell;
            m_update  <= 1'b1;
            acc_rst   <= 1'b1;
            state     <= ST_DWELL;
          end
          ST_DWELL, ST_STEP: begin
            if (dwell_cnt != '0) begin
              dwell_cnt <= dwell_cnt - 1'b1;
              state     <= ST_DWELL;
            end else if (fixed_tone || at_stop) begin
              // End of leg (a fixed tone ends its leg after every dwell).
              if (sh_mode == MODE_LOOP && !fixed_tone) begin
                m_out     <= sh_start;
                leg_start <= sh_start;
                leg_stop  <= sh_stop;
                dir_up    <= (sh_start <= sh_stop);
                dwell_cnt <= sh_dwell;
                m_update  <= 1'b1;
                acc_rst   <= 1'b1;
                state     <= ST_DWELL;
              end else if (sh_mode == MODE_PINGPONG && !fixed_tone) begin
                m_out     <= step_next;
                leg_start <= leg_stop;
                leg_stop  <= leg_start;
                dir_up    <= ~dir_up;
                dwell_cnt <= sh_dwell;
                m_update  <= 1'b1;
                state     <= ST_STEP;
              end else if (sh_mode == MODE_LOOP || sh_mode == MODE_PINGPONG) begin
                // Fixed tone in a repeating mode: keep holding start.
                dwell_cnt <= sh_dwell;
                state     <= ST_DWELL;
              end else begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_DONE;
              end
            end else begin
              m_out     <= step_next;
              dwell_cnt <= sh_dwell;
              m_update  <= 1'b1;
              state     <= ST_STEP;
            end
          end
          ST_DONE: begin
            state     <= ST_IDLE;
            cfg_ready <= 1'b1;
          end
          default: begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl: directed self-checking bench for nco_sweep_ctrl.
module tb_nco_sweep_ctrl;
  import nco_pkg::*;

  localparam int SW = 26;
  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [SW-1:0] cfg_start, cfg_stop, cfg_step;
  logic [DW-1:0] cfg_dwell;
  logic [1:0]    cfg_mode;
  logic          go, abort;
  logic [SW-1:0] m_out;
  logic          m_update, acc_rst, busy, done;
  sweep_state_t  dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  // Per-cycle samples taken 1 time unit after each rising edge.
  logic [SW-1:0] m_q[$];
  logic          upd_q[$];
  logic          rst_q[$];
  logic          done_q[$];
  logic          busy_q[$];
  logic [SW-1:0] exp_q[$];

  nco_sweep_ctrl #(.SIZE(SW), .DWELL_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_start (cfg_start),
    .cfg_stop  (cfg_stop),
    .cfg_step  (cfg_step),
    .cfg_dwell (cfg_dwell),
    .cfg_mode  (cfg_mode),
    .go        (go),
    .abort     (abort),
    .m_out     (m_out),
    .m_update  (m_update),
    .acc_rst   (acc_rst),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step_clk();
    @(posedge clk);
    #1;
    m_q.push_back(m_out);
    upd_q.push_back(m_update);
    rst_q.push_back(acc_rst);
    done_q.push_back(done);
    busy_q.push_back(busy);
  endtask

  task automatic clear_hist();
    m_q.delete(); upd_q.delete(); rst_q.delete(); done_q.delete(); busy_q.delete();
    exp_q.delete();
  endtask

  task automatic drive_cfg(input logic [SW-1:0] s, input logic [SW-1:0] e,
                           input logic [SW-1:0] st, input logic [DW-1:0] d,
                           input logic [1:0] md);
    cfg_start = s; cfg_stop = e; cfg_step = st; cfg_dwell = d; cfg_mode = md;
    cfg_valid = 1'b1;
    step_clk();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    step_clk();
    go = 1'b0;
    clear_hist();
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step_clk();
    abort = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    reset = 1'b0;
    step_clk(); step_clk();
    n_total++; if (m_out !== '0) $display("FAIL rst_m: got %0d expected 0", m_out); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (cfg_ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", cfg_ready); else n_pass++;
    n_total++; if ({done, m_update, acc_rst} !== 3'b000)
      $display("FAIL rst_pulses: got %b expected 000", {done, m_update, acc_rst}); else n_pass++;
    n_total++; if (dbg_state !== ST_IDLE) $display("FAIL rst_state: got %0d expected %0d", dbg_state, ST_IDLE); else n_pass++;
    reset = 1'b1;
    step_clk();
  endtask

  task automatic test_oneshot_up();
    logic [31:0] upd_m, rst_m, done_m, busy_m;
    drive_cfg(26'd100, 26'd130, 26'd10, 16'd2, MODE_ONESHOT);
    pulse_go();
    n_total++; if (busy !== 1'b1 || dbg_state !== ST_LOAD || m_update !== 1'b0)
      $display("FAIL t1_load: got busy=%b state=%0d upd=%b expected 1/%0d/0", busy, dbg_state, m_update, ST_LOAD); else n_pass++;
    repeat (14) step_clk();
    for (int v = 0; v < 4; v++) repeat (3) exp_q.push_back(SW'(100 + 10 * v));
    exp_q.push_back(26'd130); exp_q.push_back(26'd130);
    upd_m  = (32'd1 << 0) | (32'd1 << 3) | (32'd1 << 6) | (32'd1 << 9);
    rst_m  = 32'd1;
    done_m = 32'd1 << 12;
    busy_m = (32'd1 << 12) - 1;
    for (int i = 0; i < 14; i++) begin
      n_total++; if (m_q[i] !== exp_q[i]) $display("FAIL t1_m[%0d]: got %0d expected %0d", i, m_q[i], exp_q[i]); else n_pass++;
      n_total++; if (upd_q[i] !== upd_m[i]) $display("FAIL t1_upd[%0d]: got %b expected %b", i, upd_q[i], upd_m[i]); else n_pass++;
      n_total++; if (rst_q[i] !== rst_m[i]) $display("FAIL t1_accrst[%0d]: got %b expected %b", i, rst_q[i], rst_m[i]); else n_pass++;
      n_total++; if (done_q[i] !== done_m[i]) $display("FAIL t1_done[%0d]: got %b expected %b", i, done_q[i], done_m[i]); else n_pass++;
      n_total++; if (busy_q[i] !== busy_m[i]) $display("FAIL t1_busy[%0d]: got %b expected %b", i, busy_q[i], busy_m[i]); else n_pass++;
    end
    n_total++; if (cfg_ready !== 1'b1) $display("FAIL t1_ready_end: got %b expected 1", cfg_ready); else n_pass++;
  endtask

  task automatic test_overshoot_clamp();
    drive_cfg(26'h3FFFFF0, 26'h3FFFFFF, 26'h20, 16'd0, MODE_ONESHOT);
    pulse_go();
    repeat (4) step_clk();
    exp_q = '{26'h3FFFFF0, 26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFF};
    for (int i = 0; i < 4; i++) begin
      n_total++; if (m_q[i] !== exp_q[i]) $display("FAIL t2_m[%0d]: got %h expected %h", i, m_q[i], exp_q[i]); else n_pass++;
      n_total++; if (done_q[i] !== (i == 2)) $display("FAIL t2_done[%0d]: got %b expected %b", i, done_q[i], (i == 2)); else n_pass++;
    end
  endtask

  task automatic test_pingpong_down();
    drive_cfg(26'd50, 26'd20, 26'd15, 16'd0, MODE_PINGPONG);
    pulse_go();
    repeat (8) step_clk();
    exp_q = '{26'd50, 26'd35, 26'd20, 26'd35, 26'd50, 26'd35, 26'd20, 26'd35};
    for (int i = 0; i < 8; i++) begin
      n_total++; if (m_q[i] !== exp_q[i]) $display("FAIL t3_m[%0d]: got %0d expected %0d", i, m_q[i], exp_q[i]); else n_pass++;
      n_total++; if (upd_q[i] !== 1'b1) $display("FAIL t3_upd[%0d]: got %b expected 1", i, upd_q[i]); else n_pass++;
      n_total++; if (rst_q[i] !== (i == 0)) $display("FAIL t3_accrst[%0d]: got %b expected %b", i, rst_q[i], (i == 0)); else n_pass++;
      n_total++; if (done_q[i] !== 1'b0) $display("FAIL t3_done[%0d]: got %b expected 0", i, done_q[i]); else n_pass++;
    end
    do_abort();
    n_total++; if (busy !== 1'b0) $display("FAIL t3_abort_busy: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_loop();
    logic [31:0] upd_m, rst_m;
    drive_cfg(26'd5, 26'd7, 26'd1, 16'd1, MODE_LOOP);
    pulse_go();
    repeat (12) step_clk();
    exp_q = '{26'd5, 26'd5, 26'd6, 26'd6, 26'd7, 26'd7, 26'd5, 26'd5, 26'd6, 26'd6, 26'd7, 26'd7};
    upd_m = 32'b0101_0101_0101;
    rst_m = (32'd1 << 0) | (32'd1 << 6);
    for (int i = 0; i < 12; i++) begin
      n_total++; if (m_q[i] !== exp_q[i]) $display("FAIL t4_m[%0d]: got %0d expected %0d", i, m_q[i], exp_q[i]); else n_pass++;
      n_total++; if (upd_q[i] !== upd_m[i]) $display("FAIL t4_upd[%0d]: got %b expected %b", i, upd_q[i], upd_m[i]); else n_pass++;
      n_total++; if (rst_q[i] !== rst_m[i]) $display("FAIL t4_accrst[%0d]: got %b expected %b", i, rst_q[i], rst_m[i]); else n_pass++;
      n_total++; if (busy_q[i] !== 1'b1) $display("FAIL t4_busy[%0d]: got %b expected 1", i, busy_q[i]); else n_pass++;
    end
    do_abort();
  endtask

  task automatic test_abort();
    drive_cfg(26'd100, 26'd130, 26'd10, 16'd2, MODE_ONESHOT);
    pulse_go();
    step_clk();
    // Config write attempted while busy must be held off.
    cfg_valid = 1'b1; cfg_start = 26'd777;
    n_total++; if (cfg_ready !== 1'b0) $display("FAIL t5_ready_busy: got %b expected 0", cfg_ready); else n_pass++;
    step_clk();
    cfg_valid = 1'b0;
    repeat (3) step_clk();
    n_total++; if (m_out !== 26'd110 || dbg_state !== ST_DWELL)
      $display("FAIL t5_pre: got m=%0d state=%0d expected 110/%0d", m_out, dbg_state, ST_DWELL); else n_pass++;
    do_abort();
    n_total++; if (dbg_state !== ST_IDLE) $display("FAIL t5_state: got %0d expected %0d", dbg_state, ST_IDLE); else n_pass++;
    n_total++; if (m_out !== 26'd110) $display("FAIL t5_m_hold: got %0d expected 110", m_out); else n_pass++;
    n_total++; if (busy !== 1'b0 || cfg_ready !== 1'b1)
      $display("FAIL t5_flags: got busy=%b ready=%b expected 0/1", busy, cfg_ready); else n_pass++;
    step_clk(); step_clk();
    for (int i = 0; i < done_q.size(); i++) begin
      n_total++; if (done_q[i] !== 1'b0 || rst_q[i] !== (i == 0))
        $display("FAIL t5_pulses[%0d]: got done=%b accrst=%b expected 0/%b", i, done_q[i], rst_q[i], (i == 0)); else n_pass++;
    end
    pulse_go();
    step_clk();
    n_total++; if (m_out !== 26'd100) $display("FAIL t5_shadow: got %0d expected 100", m_out); else n_pass++;
    do_abort();
  endtask

  task automatic test_reset_midsweep();
    drive_cfg(26'd100, 26'd130, 26'd10, 16'd2, MODE_ONESHOT);
    pulse_go();
    repeat (4) step_clk();
    n_total++; if (dbg_state !== ST_STEP || m_out !== 26'd110)
      $display("FAIL t6_pre: got state=%0d m=%0d expected %0d/110", dbg_state, m_out, ST_STEP); else n_pass++;
    reset = 1'b0;
    step_clk();
    reset = 1'b1;
    n_total++; if (m_out !== '0 || busy !== 1'b0 || cfg_ready !== 1'b1)
      $display("FAIL t6_rst: got m=%0d busy=%b ready=%b expected 0/0/1", m_out, busy, cfg_ready); else n_pass++;
    go = 1'b1; abort = 1'b1;
    step_clk();
    go = 1'b0; abort = 1'b0;
    n_total++; if (dbg_state !== ST_IDLE || busy !== 1'b0)
      $display("FAIL t6_go_abort: got state=%0d busy=%b expected %0d/0", dbg_state, busy, ST_IDLE); else n_pass++;
    step_clk();
    n_total++; if (dbg_state !== ST_IDLE || acc_rst !== 1'b0)
      $display("FAIL t6_go_abort2: got state=%0d accrst=%b expected %0d/0", dbg_state, acc_rst, ST_IDLE); else n_pass++;
    // Zero step: fixed tone for one dwell, then done.
    drive_cfg(26'd40, 26'd90, 26'd0, 16'd1, MODE_ONESHOT);
    pulse_go();
    repeat (4) step_clk();
    for (int i = 0; i < 3; i++) begin
      n_total++; if (m_q[i] !== 26'd40) $display("FAIL t6_zstep_m[%0d]: got %0d expected 40", i, m_q[i]); else n_pass++;
      n_total++; if (done_q[i] !== (i == 2)) $display("FAIL t6_zstep_done[%0d]: got %b expected %b", i, done_q[i], (i == 2)); else n_pass++;
      n_total++; if (busy_q[i] !== (i != 2)) $display("FAIL t6_zstep_busy[%0d]: got %b expected %b", i, busy_q[i], (i != 2)); else n_pass++;
    end
    n_total++; if (done_q[3] !== 1'b0 || dbg_state !== ST_IDLE)
      $display("FAIL t6_zstep_end: got done=%b state=%0d expected 0/%0d", done_q[3], dbg_state, ST_IDLE); else n_pass++;
  endtask

  // Sequence and final report
  initial begin
    reset = 1'b0; cfg_valid = 1'b0; go = 1'b0; abort = 1'b0;
    cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_dwell = '0; cfg_mode = '0;
    test_reset();
    test_oneshot_up();
    test_overshoot_clamp();
    test_pingpong_down();
    test_loop();
    test_abort();
    test_reset_midsweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
